iob_cache_mem_arbiter: RTL and testbench
========================================

# iob_cache_mem_arbiter

Arbiter that shares one native back-end memory port (valid/ready, addr/wdata/wstrb/rdata) between N cache back-ends, such as the L1 instruction and data caches, ahead of a single RAM or L2. One transaction (one valid/ready handshake) is granted at a time. Grant is held until the memory returns ready. Fixed-priority or round-robin selection is chosen at compile time.

## Interface
Parameters:
- N_MASTERS, 2: number of requesting back-ends (2..8).
- ADDR_W, 32: byte-address width of master and memory ports.
- DATA_W, 32: data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  N_MASTERS  per-master request; held high until that master's m_ready.
- m_addr  in  N_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W].
- m_wdata  in  N_MASTERS*DATA_W  master i at [i*DATA_W +: DATA_W].
- m_wstrb  in  N_MASTERS*DATA_W/8  master i slice; all zero means read.
- m_rdata  out  DATA_W  mem_rdata broadcast to all masters.
- m_ready  out  N_MASTERS  one-hot ready; only the granted bit can be 1.
- mem_valid  out  1  memory request.
- mem_addr  out  ADDR_W  granted master's address.
- mem_wdata  out  DATA_W  granted master's write data.
- mem_wstrb  out  DATA_W/8  granted master's strobe.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion.
- busy  out  1  high in state BUSY.
- grant  out  clog2(N_MASTERS)  index of the current or last granted master.

## Operation
- FSM with two states:
  - IDLE: mem_valid=0, m_ready=0.
    - If any m_valid bit is set, select a winner, register it into grant and move to BUSY.
    - Otherwise stay in IDLE.
  - BUSY: mem_valid=1. mem_addr, mem_wdata and mem_wstrb are driven combinationally from master[grant].
    - When mem_ready=1, drive m_ready[grant]=1 in that same cycle and return to IDLE.
    - Otherwise stay in BUSY.
- Selection is made only in IDLE. A request that arrives while BUSY waits. No preemption.
- In IDLE, mem_addr, mem_wdata and mem_wstrb still mirror master[grant], but mem_valid=0.
- m_rdata = mem_rdata at all times. Masters qualify it with their own m_ready bit.
- mem_ready arriving in IDLE is ignored. This covers a stale response after reset.
- If m_valid[grant] drops while BUSY (a protocol violation), the request is still completed and m_ready still pulses.
- Requests for masters not selected remain pending and are never lost.

## Timing
- Reset values:
  - state=IDLE, grant=0, busy=0.
  - mem_valid=0, m_ready=0.
  - The round-robin pointer is set to 0 (lowest index has first priority).
- Arbitration latency:
  - m_valid is sampled at edge t in IDLE.
  - mem_valid=1 in cycle t+1.
- Completion:
  - mem_ready=1 in cycle k gives m_ready[grant]=1 in cycle k with zero added latency.
  - The FSM is in IDLE at k+1.
- Back-to-back requests leave one dead IDLE cycle between transactions. With a 1-cycle RAM (mem_ready is mem_valid registered), each access takes 3 cycles from request sampling.
- Simultaneous requests in IDLE are resolved by the priority rule in the same cycle.
- reset high while BUSY: the FSM is in IDLE at the next edge, the transaction is abandoned and no m_ready is produced.

## Configuration
- IOB_CACHE_ARB_RR_EN undefined: fixed priority. The lowest index among asserted m_valid bits wins.
- IOB_CACHE_ARB_RR_EN defined: round-robin.
  - On each grant, the pointer becomes (winner+1) mod N_MASTERS.
  - The winner is the first asserted m_valid bit at or after the pointer, searching with wrap-around.
  - With N masters continuously requesting, each is served once every N transactions.

## Test plan
- Single read: master 1 requests addr 0x1234, wstrb=0 → mem_valid rises 1 cycle later with mem_addr=0x1234. m_ready=2'b10 in the mem_ready cycle and m_rdata equals the RAM word. busy returns to 0 the next cycle.
- Write then read: master 0 writes 0xDEADBEEF with wstrb=4'hF to 0x1234, then reads the same address → the read returns 0xDEADBEEF. m_ready[1] stays 0 throughout.
- Simultaneous requests: masters 0 and 1 both request from reset.
  - Without the macro: grants are 0,0,0… while master 0 keeps requesting, and master 1 starves.
  - With IOB_CACHE_ARB_RR_EN: grant sequence is 0,1,0,1.
- Request while busy: master 1 asserts valid during master 0's BUSY → master 1 is granted only after master 0's m_ready plus 1 idle cycle. Its address appears on mem_addr unchanged.
- Reset mid-transaction: reset asserted while BUSY, and the RAM's mem_ready arrives in the following cycle → mem_valid=0, m_ready=0, grant=0. The stale mem_ready is ignored.
- Wrap-around (N_MASTERS=3, RR enabled): masters 2 and 0 both request with pointer=2 → master 2 is granted, then master 0 (pointer wraps to 0).

Source files
------------

// File: rtl/iob_cache_mem_arbiter.sv
// Shares one native memory port between N cache back-ends, one transaction at a time.
// Fixed priority by default; define IOB_CACHE_ARB_RR_EN for round-robin selection.
module iob_cache_mem_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_MASTERS-1:0]              m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]       m_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
    output logic [DATA_W-1:0]                 m_rdata,
    output logic [N_MASTERS-1:0]              m_ready,
    output logic                              mem_valid,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    output logic [DATA_W/8-1:0]               mem_wstrb,
    input  logic [DATA_W-1:0]                 mem_rdata,
    input  logic                              mem_ready,
    output logic                              busy,
    output logic [$clog2(N_MASTERS)-1:0]      grant
);

    localparam int GW = $clog2(N_MASTERS);
    localparam int SW = DATA_W / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   winner;

`ifdef IOB_CACHE_ARB_RR_EN
    logic [GW-1:0]   ptr_q;
    logic            found;
    int              idx;

    // First requester at or after the pointer, wrapping past the top index.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!found && m_valid[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            if (m_valid[k]) winner = GW'(k);
        end
    end
`endif

    // Handshake: a master holds m_valid until its m_ready; mem_valid stays high
    // from grant until mem_ready, and that same cycle pulses m_ready[grant].
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
`ifdef IOB_CACHE_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|m_valid) begin
                        grant_q <= winner;
                        state_q <= BUSY;
`ifdef IOB_CACHE_ARB_RR_EN
                        ptr_q   <= (winner == GW'(N_MASTERS - 1)) ? '0 : winner + GW'(1);
`endif
                    end
                end
                BUSY: begin
                    if (mem_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q == BUSY);
    assign mem_valid = (state_q == BUSY);
    assign grant     = grant_q;
    assign m_rdata   = mem_rdata;

    // Request fields always mirror the granted master, even while idle.
    assign mem_addr  = m_addr[int'(grant_q)*ADDR_W +: ADDR_W];
    assign mem_wdata = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
    assign mem_wstrb = m_wstrb[int'(grant_q)*SW +: SW];

    // A response arriving while idle is stale and never reaches a master.
    always_comb begin
        m_ready = '0;
        if (state_q == BUSY && mem_ready) m_ready[grant_q] = 1'b1;
    end

endmodule

// File: tb/tb_iob_cache_mem_arbiter.sv
// Bench for iob_cache_mem_arbiter with three masters against a transaction-level model
// and a behavioural RAM; follows IOB_CACHE_ARB_RR_EN for the expected selection policy.
module tb_iob_cache_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int GW = $clog2(N);
`ifdef IOB_CACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic [N-1:0]      m_valid;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_ready;
    logic              mem_valid;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [SW-1:0]     mem_wstrb;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ready;
    logic              busy;
    logic [GW-1:0]     grant;

    iob_cache_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant(grant)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model / scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] cur_addr [N];
    logic [DW-1:0] cur_wdata[N];
    logic [SW-1:0] cur_strb [N];
    int            remaining[N];
    int            start_at [N];

    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_q[$];

    bit  mdl_busy;
    int  mdl_grant;
    int  mdl_ptr;
    int  grant_log[$];
    int  done_cyc[$];
    logic [DW-1:0] last_rdata;
    logic [N-1:0]  last_ready;

    function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic void ref_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [SW-1:0] s);
        logic [DW-1:0] w;
        w = ref_rd(a);
        for (int b = 0; b < SW; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
    endfunction

    function automatic void dev_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [SW-1:0] s);
        logic [DW-1:0] w;
        w = dev_rd(a);
        for (int b = 0; b < SW; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        dev_mem[a] = w;
    endfunction

    // Selection rule: lowest index, or first requester at/after the pointer with wrap.
    function automatic int pick(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = RR ? (ptr + k) % N : k;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic new_req(input int i);
        cur_addr[i]  = 32'h1000 + 32'($urandom_range(0, 15) * 4);
        cur_wdata[i] = $urandom;
        cur_strb[i]  = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
    endtask

    task automatic load_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input int cnt, input int st);
        cur_addr[i]  = a;
        cur_wdata[i] = d;
        cur_strb[i]  = s;
        remaining[i] = cnt;
        start_at[i]  = st;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            remaining[i] = 0;
            start_at[i]  = 0;
            new_req(i);
        end
        grant_log.delete();
        done_cyc.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        m_valid   = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        mdl_busy  = 1'b0;
        mdl_grant = 0;
        mdl_ptr   = 0;
    endtask

    // Cycle engine: drives masters and RAM from the model, checks every cycle.
    // Entered and left just after a rising edge. fixed_lat < 0 means random latency.
    task automatic run_engine(input int budget, input int fixed_lat);
        int cyc;
        int lat;
        int lat_cnt;
        int g;
        int w;
        bit done;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] mask;
        cyc = 0; lat = 0; lat_cnt = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i]            = (remaining[i] > 0) && (cyc >= start_at[i]);
                m_addr[i*AW +: AW]    = cur_addr[i];
                m_wdata[i*DW +: DW]   = cur_wdata[i];
                m_wstrb[i*SW +: SW]   = cur_strb[i];
            end
            mask      = m_valid;
            mem_ready = mdl_busy && (lat_cnt == lat);
            #1;
            mem_rdata = mdl_busy ? dev_rd(mem_addr) : DW'($urandom);
            @(negedge clk);
            exp_rdy = '0;
            if (mdl_busy && mem_ready) exp_rdy[mdl_grant] = 1'b1;

            n_checks++;
            if (mem_valid !== mdl_busy) $display("FAIL mem_valid cyc %0d: got %b expected %b", cyc, mem_valid, mdl_busy);
            else n_pass++;
            n_checks++;
            if (busy !== mdl_busy) $display("FAIL busy cyc %0d: got %b expected %b", cyc, busy, mdl_busy);
            else n_pass++;
            n_checks++;
            if (grant !== GW'(mdl_grant)) $display("FAIL grant cyc %0d: got %0d expected %0d", cyc, grant, mdl_grant);
            else n_pass++;
            n_checks++;
            if (m_ready !== exp_rdy) $display("FAIL m_ready cyc %0d: got %b expected %b", cyc, m_ready, exp_rdy);
            else n_pass++;
            n_checks++;
            if (mem_addr !== cur_addr[mdl_grant]) $display("FAIL mem_addr cyc %0d: got %h expected %h", cyc, mem_addr, cur_addr[mdl_grant]);
            else n_pass++;
            n_checks++;
            if (mem_wdata !== cur_wdata[mdl_grant] || mem_wstrb !== cur_strb[mdl_grant])
                $display("FAIL mem_wdata/wstrb cyc %0d: got %h/%h expected %h/%h", cyc, mem_wdata, mem_wstrb, cur_wdata[mdl_grant], cur_strb[mdl_grant]);
            else n_pass++;
            n_checks++;
            if (m_rdata !== mem_rdata) $display("FAIL m_rdata cyc %0d: got %h expected %h", cyc, m_rdata, mem_rdata);
            else n_pass++;

            if (mdl_busy && mem_ready) begin
                g = mdl_grant;
                if (mem_wstrb != '0) dev_wr(mem_addr, mem_wdata, mem_wstrb);
                if (cur_strb[g] == '0) begin
                    exp_q.push_back(ref_rd(cur_addr[g]));
                    n_checks++;
                    if (m_rdata !== exp_q[0]) $display("FAIL read_data m%0d addr %h: got %h expected %h", g, cur_addr[g], m_rdata, exp_q[0]);
                    else n_pass++;
                    void'(exp_q.pop_front());
                end else begin
                    ref_wr(cur_addr[g], cur_wdata[g], cur_strb[g]);
                end
                last_rdata = m_rdata;
                last_ready = m_ready;
                grant_log.push_back(int'(grant));
                done_cyc.push_back(cyc);
                remaining[g]--;
                if (remaining[g] > 0) new_req(g);
                mdl_busy = 1'b0;
            end else if (mdl_busy) begin
                lat_cnt++;
            end else if (mask != '0) begin
                w         = pick(mask, mdl_ptr);
                mdl_grant = w;
                mdl_ptr   = (w + 1) % N;
                mdl_busy  = 1'b1;
                lat_cnt   = 0;
                lat       = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
            end
            @(posedge clk);
            #1;
            cyc++;
            done = !mdl_busy;
            for (int i = 0; i < N; i++) if (remaining[i] > 0) done = 1'b0;
        end
        n_checks++;
        if (!done) $display("FAIL engine_timeout: got %0d cycles expected completion within %0d", cyc, budget);
        else n_pass++;
        m_valid   = '0;
        mem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        m_valid   = '1;
        mem_ready = 1'b1;
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_valid !== 1'b0) $display("FAIL reset_idle: got busy=%b mem_valid=%b expected 0/0", busy, mem_valid);
        else n_pass++;
        n_checks++;
        if (m_ready !== '0) $display("FAIL reset_m_ready: got %b expected 0", m_ready);
        else n_pass++;
        n_checks++;
        if (grant !== '0) $display("FAIL reset_grant: got %0d expected 0", grant);
        else n_pass++;
        m_valid   = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b expected 0", busy);
        else n_pass++;
        @(posedge clk);
        #1;
        mdl_busy = 1'b0; mdl_grant = 0; mdl_ptr = 0;
    endtask

    task automatic test_single_read();
        clear_reqs();
        dev_mem[32'h1234] = 32'hCAFE_0001;
        ref_mem[32'h1234] = 32'hCAFE_0001;
        load_req(1, 32'h1234, 32'h0, '0, 1, 0);
        run_engine(20, 1);
        n_checks++;
        if (last_ready !== 3'b010) $display("FAIL single_read_ready: got %b expected 010", last_ready);
        else n_pass++;
        n_checks++;
        if (last_rdata !== 32'hCAFE_0001) $display("FAIL single_read_data: got %h expected cafe0001", last_rdata);
        else n_pass++;
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 2) $display("FAIL single_read_latency: got %0d expected 2", done_cyc.size() > 0 ? done_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_write_then_read();
        clear_reqs();
        load_req(0, 32'h1234, 32'hDEAD_BEEF, 4'hF, 1, 0);
        run_engine(20, 1);
        clear_reqs();
        load_req(0, 32'h1234, 32'h0, '0, 1, 0);
        run_engine(20, $urandom_range(0, 2));
        n_checks++;
        if (last_rdata !== 32'hDEAD_BEEF) $display("FAIL write_then_read: got %h expected deadbeef", last_rdata);
        else n_pass++;
        n_checks++;
        if (last_ready !== 3'b001) $display("FAIL write_then_read_ready: got %b expected 001", last_ready);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int exp_seq;
        do_reset();
        clear_reqs();
        remaining[0] = 4;
        remaining[1] = 4;
        run_engine(100, -1);
        for (int k = 0; k < 8; k++) begin
            exp_seq = RR ? (k % 2) : (k < 4 ? 0 : 1);
            n_checks++;
            if (k >= grant_log.size() || grant_log[k] != exp_seq)
                $display("FAIL simultaneous_grant[%0d]: got %0d expected %0d", k, k < grant_log.size() ? grant_log[k] : -1, exp_seq);
            else n_pass++;
        end
    endtask

    task automatic test_request_while_busy();
        clear_reqs();
        load_req(0, 32'h2000, 32'h1111_2222, 4'h3, 1, 0);
        load_req(1, 32'h5678, 32'h0, '0, 1, 2);
        run_engine(30, 2);
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1)
            $display("FAIL busy_wait_order: got %0d entries expected 0 then 1", grant_log.size());
        else n_pass++;
        n_checks++;
        if (done_cyc.size() != 2 || done_cyc[1] - done_cyc[0] != 4)
            $display("FAIL busy_wait_spacing: got %0d expected 4", done_cyc.size() == 2 ? done_cyc[1] - done_cyc[0] : -1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_reqs();
        remaining[2] = 4;
        run_engine(40, 1);
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (k >= done_cyc.size() || done_cyc[k] - done_cyc[k-1] != 3)
                $display("FAIL back_to_back_period[%0d]: got %0d expected 3", k, k < done_cyc.size() ? done_cyc[k] - done_cyc[k-1] : -1);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_transaction();
        m_valid             = 3'b100;
        m_addr[2*AW +: AW]  = 32'h0000_0AB0;
        m_wstrb             = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || grant !== 2'd2) $display("FAIL reset_mid_grant: got busy=%b grant=%0d expected 1/2", busy, grant);
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        m_valid   = '0;
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_mid_idle: got mem_valid=%b busy=%b expected 0/0", mem_valid, busy);
        else n_pass++;
        n_checks++;
        if (m_ready !== '0) $display("FAIL reset_mid_stale_ready: got %b expected 000", m_ready);
        else n_pass++;
        n_checks++;
        if (grant !== '0) $display("FAIL reset_mid_grant_cleared: got %0d expected 0", grant);
        else n_pass++;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_mid_stays_idle: got %b expected 0", busy);
        else n_pass++;
        @(posedge clk);
        #1;
        mdl_busy = 1'b0; mdl_grant = 0; mdl_ptr = 0;
    endtask

    task automatic test_wrap_around();
        do_reset();
        clear_reqs();
        remaining[1] = 1;
        run_engine(20, 0);
        clear_reqs();
        remaining[2] = 1;
        remaining[0] = 1;
        run_engine(30, 1);
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] != (RR ? 2 : 0) || grant_log[1] != (RR ? 0 : 2))
            $display("FAIL wrap_order: got %0d,%0d expected %0d,%0d",
                     grant_log.size() > 0 ? grant_log[0] : -1, grant_log.size() > 1 ? grant_log[1] : -1,
                     RR ? 2 : 0, RR ? 0 : 2);
        else n_pass++;
    endtask

    task automatic test_random();
        clear_reqs();
        for (int i = 0; i < N; i++) begin
            remaining[i] = $urandom_range(3, 8);
            start_at[i]  = $urandom_range(0, 10);
        end
        run_engine(2000, -1);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL random_scoreboard_drain: got %0d expected 0", exp_q.size());
        else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mdl_busy = 1'b0; mdl_grant = 0; mdl_ptr = 0;
        clear_reqs();
        test_reset();
        test_single_read();
        test_write_then_read();
        test_simultaneous();
        test_request_while_busy();
        test_back_to_back();
        test_reset_mid_transaction();
        test_wrap_around();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
